// File: rtl/clk_monitor.sv
// clk_monitor: measures the period of a slow asynchronous clock (clk_in) in
// clk cycles, detects frequency lock and sticky loss of clk_in.
// Optional macro CLK_MONITOR_DUTY_EN adds a high-phase (high_time) counter;
// without it high_time is tied to zero.
module clk_monitor #(
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned TIMEOUT     = 1024,
   parameter int unsigned LOCK_COUNT  = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clk_in,
   input  logic             clear,
   output logic             rise_pulse,
   output logic             fall_pulse,
   output logic [CNT_W-1:0] period,
   output logic             period_valid,
   output logic             lock,
   output logic             clk_lost,
   output logic [CNT_W-1:0] high_time
);

   localparam int unsigned      MATCH_W    = 4;
   localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [MATCH_W-1:0] MATCH_LOCK = MATCH_W'(LOCK_COUNT);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_MEASURE = 2'd1,
      S_LOCKED  = 2'd2,
      S_LOST    = 2'd3
   } state_t;

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_hist;
   logic                   r_rise;
   logic                   r_fall;
   logic [CNT_W-1:0]       r_cnt;
   logic [CNT_W-1:0]       r_period;
   logic                   r_valid;
   logic                   r_lock;
   logic                   r_lost;
   logic [MATCH_W-1:0]     r_match;
   logic                   r_first;
   state_t                 r_state;

   logic                   w_sync;
   logic                   w_cnt_sat;
   logic [MATCH_W-1:0]     w_match_inc;
   state_t                 w_state_nxt;
   logic                   w_capture;
   logic [MATCH_W-1:0]     w_match_nxt;
   logic                   w_first_nxt;
   logic                   w_lost_set;

   assign w_sync      = r_sync[SYNC_STAGES-1];
   assign w_cnt_sat   = (r_cnt == CNT_MAX);
   assign w_match_inc = r_match + MATCH_W'(1);

   // Synchronizer chain plus history flop; only reset touches these
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync <= '0;
         r_hist <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], clk_in};
         r_hist <= w_sync;
      end
   end

   // Registered edge pulses from the synchronized clk_in
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else if (clear) begin
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_rise <= w_sync & ~r_hist;
         r_fall <= ~w_sync & r_hist;
      end
   end

   // Rise-to-rise cycle counter, restarts at 1 on each rise, saturates at TIMEOUT
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (clear) begin
         r_cnt <= '0;
      end else if (r_rise) begin
         r_cnt <= CNT_ONE;
      end else if (!w_cnt_sat) begin
         r_cnt <= r_cnt + CNT_ONE;
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next-state and datapath controls; a rise beats a same-cycle timeout
   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      w_match_nxt = r_match;
      w_first_nxt = r_first;
      w_lost_set  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_rise) begin
               w_state_nxt = S_MEASURE;
               w_match_nxt = '0;
               w_first_nxt = 1'b1;
            end
         end
         S_MEASURE: begin
            if (r_rise) begin
               w_capture   = 1'b1;
               w_first_nxt = 1'b0;
               if (!r_first && (r_cnt == r_period)) begin
                  w_match_nxt = w_match_inc;
                  if (w_match_inc == MATCH_LOCK) begin
                     w_state_nxt = S_LOCKED;
                  end
               end else begin
                  w_match_nxt = '0;
               end
            end else if (w_cnt_sat) begin
               w_state_nxt = S_LOST;
               w_lost_set  = 1'b1;
               w_match_nxt = '0;
            end
         end
         S_LOCKED: begin
            if (r_rise) begin
               w_capture = 1'b1;
               if (r_cnt != r_period) begin
                  w_state_nxt = S_MEASURE;
                  w_match_nxt = '0;
               end
            end else if (w_cnt_sat) begin
               w_state_nxt = S_LOST;
               w_lost_set  = 1'b1;
               w_match_nxt = '0;
            end
         end
         S_LOST: begin
            if (r_rise) begin
               w_state_nxt = S_MEASURE;
               w_match_nxt = '0;
               w_first_nxt = 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
      if (clear) begin
         w_state_nxt = S_IDLE;
         w_capture   = 1'b0;
         w_match_nxt = '0;
         w_first_nxt = 1'b0;
         w_lost_set  = 1'b0;
      end
   end

   // Period capture, match tracking, lock and sticky loss flags
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_period <= '0;
         r_valid  <= 1'b0;
         r_lock   <= 1'b0;
         r_lost   <= 1'b0;
         r_match  <= '0;
         r_first  <= 1'b0;
      end else begin
         r_valid <= w_capture;
         r_lock  <= (w_state_nxt == S_LOCKED);
         r_match <= w_match_nxt;
         r_first <= w_first_nxt;
         if (clear) begin
            r_period <= '0;
            r_lost   <= 1'b0;
         end else begin
            if (w_capture) begin
               r_period <= r_cnt;
            end
            if (w_lost_set) begin
               r_lost <= 1'b1;
            end
         end
      end
   end

`ifdef CLK_MONITOR_DUTY_EN
   logic [CNT_W-1:0] r_hcnt;
   logic [CNT_W-1:0] r_high;

   // High-phase counter: restarts on rise, saturates, captured on fall while measuring
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_hcnt <= '0;
         r_high <= '0;
      end else if (clear) begin
         r_hcnt <= '0;
         r_high <= '0;
      end else begin
         if (r_rise) begin
            r_hcnt <= CNT_ONE;
         end else if (r_hcnt != CNT_MAX) begin
            r_hcnt <= r_hcnt + CNT_ONE;
         end
         if (r_fall && ((r_state == S_MEASURE) || (r_state == S_LOCKED))) begin
            r_high <= r_hcnt;
         end
      end
   end

   assign high_time = r_high;
`else
   assign high_time = '0;
`endif

   assign rise_pulse   = r_rise;
   assign fall_pulse   = r_fall;
   assign period       = r_period;
   assign period_valid = r_valid;
   assign lock         = r_lock;
   assign clk_lost     = r_lost;

endmodule

// File: tb/tb_clk_monitor.sv
// Testbench for clk_monitor: table-driven clk_in waveforms with a scoreboard
// of expected captures, plus hand-written loss, clear and reset sequences.
module tb_clk_monitor;

   localparam int unsigned CNT_W       = 16;
   localparam int unsigned SYNC_STAGES = 2;
   localparam int unsigned TIMEOUT     = 64;
   localparam int unsigned LOCK_COUNT  = 3;
`ifdef CLK_MONITOR_DUTY_EN
   localparam bit DUTY = 1'b1;
`else
   localparam bit DUTY = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset;
   logic             clk_in;
   logic             clear;
   logic             rise_pulse;
   logic             fall_pulse;
   logic [CNT_W-1:0] period;
   logic             period_valid;
   logic             lock;
   logic             clk_lost;
   logic [CNT_W-1:0] high_time;

   typedef struct {
      int hi;
      int lo;
      bit cap;
      int per;
      bit lk;
      int ht;
   } vec_t;

   typedef struct {
      int per;
      bit lk;
      int ht;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   last_valid_cyc = 0;

   clk_monitor #(
      .CNT_W(CNT_W),
      .SYNC_STAGES(SYNC_STAGES),
      .TIMEOUT(TIMEOUT),
      .LOCK_COUNT(LOCK_COUNT)
   ) dut (
      .clk(clk),
      .reset(reset),
      .clk_in(clk_in),
      .clear(clear),
      .rise_pulse(rise_pulse),
      .fall_pulse(fall_pulse),
      .period(period),
      .period_valid(period_valid),
      .lock(lock),
      .clk_lost(clk_lost),
      .high_time(high_time)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_rise_pulse"}, 64'(rise_pulse), 64'd0);
      chk({tag, "_fall_pulse"}, 64'(fall_pulse), 64'd0);
      chk({tag, "_period"}, 64'(period), 64'd0);
      chk({tag, "_period_valid"}, 64'(period_valid), 64'd0);
      chk({tag, "_lock"}, 64'(lock), 64'd0);
      chk({tag, "_clk_lost"}, 64'(clk_lost), 64'd0);
      chk({tag, "_high_time"}, 64'(high_time), 64'd0);
   endtask

   // One clk_in cycle starting with a rise; pushes the capture that rise should produce
   task automatic run_row(input vec_t v);
      exp_t e;
      if (v.cap) begin
         e.per = v.per;
         e.lk  = v.lk;
         e.ht  = DUTY ? v.ht : 0;
         sb_q.push_back(e);
      end
      clk_in = 1'b1;
      repeat (v.hi) @(negedge clk);
      clk_in = 1'b0;
      repeat (v.lo) @(negedge clk);
   endtask

   // Scoreboard: every period_valid strobe must match the oldest expected capture
   always @(negedge clk) begin
      if (reset === 1'b1 && period_valid === 1'b1) begin
         last_valid_cyc = cyc;
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_valid: got strobe with period %0d expected no strobe (t=%0t)",
                     period, $time);
         end else begin
            mon_e = sb_q.pop_front();
            chk("sb_period", 64'(period), 64'(mon_e.per));
            chk("sb_lock", 64'(lock), 64'(mon_e.lk));
            chk("sb_high_time", 64'(high_time), 64'(mon_e.ht));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[10];
      vec_t seq[5];
      int   w;

      // period 6 locks on the 5th rise, stretch to 8 unlocks, three matches of 8 re-lock
      tbl[0] = '{3, 3, 1'b0, 0, 1'b0, 0};
      tbl[1] = '{3, 3, 1'b1, 6, 1'b0, 3};
      tbl[2] = '{3, 3, 1'b1, 6, 1'b0, 3};
      tbl[3] = '{3, 3, 1'b1, 6, 1'b0, 3};
      tbl[4] = '{3, 5, 1'b1, 6, 1'b1, 3};
      tbl[5] = '{4, 4, 1'b1, 8, 1'b0, 3};
      tbl[6] = '{4, 4, 1'b1, 8, 1'b0, 4};
      tbl[7] = '{4, 4, 1'b1, 8, 1'b0, 4};
      tbl[8] = '{4, 4, 1'b1, 8, 1'b1, 4};
      tbl[9] = '{4, 2, 1'b1, 8, 1'b1, 4};

      reset  = 1'b0;
      clk_in = 1'b0;
      clear  = 1'b0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      reset = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 10; i++) run_row(tbl[i]);

      // Loss: clk_in held low after lock
      w = 0;
      while (clk_lost !== 1'b1 && w < 300) begin
         @(negedge clk);
         w++;
      end
      chk("lost_seen", 64'(clk_lost), 64'd1);
      chk("lost_delay", 64'(cyc - last_valid_cyc), 64'(TIMEOUT));
      chk("lost_lock", 64'(lock), 64'd0);

      // Restart after loss: no capture on first rise, clk_lost stays set
      seq[0] = '{3, 3, 1'b0, 0, 1'b0, 0};
      seq[1] = '{3, 3, 1'b1, 6, 1'b0, 3};
      seq[2] = '{3, 3, 1'b1, 6, 1'b0, 3};
      for (int i = 0; i < 3; i++) run_row(seq[i]);
      chk("lost_sticky", 64'(clk_lost), 64'd1);

      // Clear coinciding with a rise pulse; also checks edge-to-pulse latency
      clk_in = 1'b1;
      @(negedge clk);
      chk("rise_lat1", 64'(rise_pulse), 64'd0);
      @(negedge clk);
      chk("rise_lat2", 64'(rise_pulse), 64'd0);
      @(negedge clk);
      chk("rise_lat3", 64'(rise_pulse), 64'd1);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      chk_all_zero("clear");
      clk_in = 1'b0;
      repeat (3) @(negedge clk);

      // Period exactly TIMEOUT: rise wins, capture TIMEOUT, no loss
      seq[0] = '{32, 32, 1'b0, 0, 1'b0, 0};
      seq[1] = '{3, 3, 1'b1, int'(TIMEOUT), 1'b0, 32};
      seq[2] = '{3, 3, 1'b1, 6, 1'b0, 3};
      for (int i = 0; i < 3; i++) run_row(seq[i]);
      chk("no_lost_at_boundary", 64'(clk_lost), 64'd0);

      // Reset mid-period: no partial period reported afterwards
      clk_in = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk_all_zero("midreset");
      reset = 1'b1;
      repeat (4) @(negedge clk);
      clk_in = 1'b0;
      repeat (20) @(negedge clk);

      w = 0;
      while (sb_q.size() != 0 && w < 50) begin
         @(negedge clk);
         w++;
      end
      chk("sb_drained", 64'(sb_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/clk_monitor.md
CLK_MONITOR -- requirements
Module: clk_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the period counter and of the period and high_time outputs.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: number of synchronizer flops on clk_in; legal values are 2 or more.
REQ-003 SHALL have parameter TIMEOUT, default 1024: clk cycles without a rising edge before loss is declared; legal range is 2 to 2^CNT_W-1.
REQ-004 SHALL have parameter LOCK_COUNT, default 3: consecutive matching periods required for lock; legal range is 1 to 15.
REQ-005 SHALL have input clk, 1 bit: system clock; every flop uses its rising edge.
REQ-006 SHALL have input reset, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have input clk_in, 1 bit: slow clock under measurement (for example a divided clock), asynchronous to clk.
REQ-008 SHALL have input clear, 1 bit: synchronous soft clear.
REQ-009 SHALL have outputs rise_pulse and fall_pulse, 1 bit each: one-cycle pulses on synchronized clk_in edges.
REQ-010 SHALL have output period, CNT_W bits: last measured rising-to-rising interval, in clk cycles.
REQ-011 SHALL have output period_valid, 1 bit: one-cycle strobe whenever period updates.
REQ-012 SHALL have outputs lock and clk_lost, 1 bit each: clk_lost is sticky.
REQ-013 SHALL have output high_time, CNT_W bits: clk_in high duration, in clk cycles.

Function
REQ-014 SHALL pass clk_in through SYNC_STAGES flops, followed by one history flop.
REQ-015 SHALL register rise_pulse = sync & ~hist and fall_pulse = ~sync & hist, giving an edge-to-pulse latency of SYNC_STAGES+1 clk cycles.
REQ-016 SHALL implement FSM states IDLE, MEASURE, LOCKED and LOST.
REQ-017 SHALL set cnt to 1 on every rise_pulse and otherwise increment it, saturating at TIMEOUT.
REQ-018 In IDLE, a rise SHALL move the FSM to MEASURE without updating period.
REQ-019 In MEASURE or LOCKED, a rise SHALL load period <= cnt and assert period_valid for one cycle.
REQ-020 In MEASURE, when a captured period equals the previous capture, the match counter SHALL increment; otherwise it SHALL clear to 0.
REQ-021 The first capture after IDLE or LOST SHALL count as a mismatch.
REQ-022 MEASURE SHALL move to LOCKED on the cycle match reaches LOCK_COUNT; lock SHALL be high exactly while the FSM is in LOCKED.
REQ-023 In LOCKED, a capture differing from the locked period SHALL move the FSM to MEASURE, clear match and deassert lock on the next cycle.
REQ-024 In MEASURE or LOCKED, cnt==TIMEOUT with no rise SHALL move the FSM to LOST, set clk_lost and drop lock.
REQ-025 If a rise and cnt==TIMEOUT occur in the same cycle, the rise SHALL win.
REQ-026 In LOST, a rise SHALL move the FSM to MEASURE without capture; clk_lost SHALL remain set until clear or reset.
REQ-027 clear SHALL force IDLE and zero cnt, match, period, high_time, period_valid, lock and clk_lost on the next edge.
REQ-028 clear SHALL take priority over any simultaneous edge or timeout.
REQ-029 Synchronizer flops SHALL be unaffected by clear.
REQ-030 All counter arithmetic SHALL be unsigned CNT_W bits; no counter SHALL wrap.

Reset
REQ-031 reset low SHALL asynchronously clear all flops, including synchronizers: FSM=IDLE and all outputs 0.
REQ-032 reset deasserted mid-period SHALL restart from IDLE; no partial period SHALL be reported.

Configuration
REQ-033 With macro CLK_MONITOR_DUTY_EN defined, a high-phase counter SHALL count from rise_pulse to fall_pulse, saturating at TIMEOUT, and load high_time on fall_pulse in MEASURE or LOCKED.
REQ-034 Without CLK_MONITOR_DUTY_EN, high_time SHALL be tied to 0 and the high-phase counter SHALL not be instantiated.

Verification
REQ-035 clk_in period of 6 clk cycles, LOCK_COUNT=3 -> period=6 with period_valid from the 2nd rise; lock=1 after the 5th rise.
REQ-036 While locked, stretch one clk_in period to 8 -> period=8, lock drops; it re-locks after 3 further matches of 8.
REQ-037 TIMEOUT=64 with clk_in held low after lock -> clk_lost=1 and lock=0 once cnt reaches 64; restarting clk_in leaves clk_lost=1 until clear.
REQ-038 A rise in the same cycle as cnt==TIMEOUT -> no LOST; period=TIMEOUT captured.
REQ-039 clear asserted together with a rise -> next cycle all outputs 0, FSM=IDLE, no period_valid.
REQ-040 CLK_MONITOR_DUTY_EN defined, clk_in high 3 and low 3 cycles -> high_time=3; macro undefined -> high_time=0.
